// File: rtl/audio_mix_pkg.sv
// Shared sizing helpers for the N-channel audio mixer.
package audio_mix_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Worst-case sum width: one bit of gain headroom plus one bit per tree level.
  function automatic int unsigned sum_w(input int unsigned in_w, input int unsigned channels);
    return in_w + 1 + clog2(channels);
  endfunction

  function automatic int unsigned unity_gain(input int unsigned gain_w);
    return 32'd1 << (gain_w - 1);
  endfunction

endpackage

// File: rtl/mixer_add_stage.sv
// One registered adder-tree level: PAIRS adjacent operand pairs summed, widened by one bit.
module mixer_add_stage #(
  parameter int unsigned PAIRS = 1,
  parameter int unsigned W     = 9
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [2*PAIRS*W-1:0]     operands,
  output logic                     out_valid,
  output logic [PAIRS*(W+1)-1:0]   sums
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) out_valid <= 1'b0;
    else         out_valid <= in_valid;
  end

  // Data path carries no reset; only the valid bit qualifies it.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < PAIRS; p++) begin
      sums[p*(W+1) +: W+1] <= (W+1)'(operands[2*p*W +: W]) + (W+1)'(operands[(2*p+1)*W +: W]);
    end
  end

endmodule

// File: rtl/audio_mixer_n.sv
// N-channel mixer: per-channel gain/mute, registered adder tree, left-justified output, peak meter.
module audio_mixer_n
  import audio_mix_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned GAIN_W   = 4,
  parameter int unsigned OUT_W    = 32,
  localparam int unsigned SEL_W   = clog2(CHANNELS),
  localparam int unsigned SUM_W   = sum_w(IN_W, CHANNELS)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [CHANNELS*IN_W-1:0] audio_in,
  input  logic [CHANNELS-1:0]      mute,
  input  logic                     gain_we,
  input  logic [SEL_W-1:0]         gain_sel,
  input  logic [GAIN_W-1:0]        gain_data,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         mix_down,
  output logic [SUM_W-1:0]         peak_level,
  input  logic                     peak_clr
);

  localparam int unsigned LEVELS = SEL_W;
  localparam int unsigned SC_W   = IN_W + 1;
  localparam int unsigned PROD_W = IN_W + GAIN_W;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_W));

  logic [GAIN_W-1:0]        gain_q [CHANNELS];
  logic [PROD_W-1:0]        prod;
  logic [CHANNELS*SC_W-1:0] scaled_d;
  logic [CHANNELS*SC_W-1:0] scaled_q;
  logic                     g_valid;
  logic [SUM_W-1:0]         tree_sum;
  logic                     tree_valid;
  logic [SUM_W-1:0]         cur_sum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned c = 0; c < CHANNELS; c++) gain_q[c] <= UNITY;
    end else if (gain_we) begin
      gain_q[gain_sel] <= gain_data;
    end
  end

  // Gain stage reads gain_q before any same-cycle write lands, so that frame keeps the old gain.
  always_comb begin
    scaled_d = '0;
    prod     = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      prod = PROD_W'(audio_in[c*IN_W +: IN_W]) * PROD_W'(gain_q[c]);
      scaled_d[c*SC_W +: SC_W] = mute[c] ? '0 : SC_W'(prod >> (GAIN_W - 1));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) g_valid <= 1'b0;
    else         g_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    scaled_q <= scaled_d;
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned PAIRS = CHANNELS >> (l + 1);
    localparam int unsigned W     = IN_W + 1 + l;
    logic [2*PAIRS*W-1:0]   ops;
    logic [PAIRS*(W+1)-1:0] sums;
    logic                   v_in;
    logic                   v_out;
    if (l == 0) begin : g_first
      assign ops  = scaled_q;
      assign v_in = g_valid;
    end else begin : g_next
      assign ops  = g_lvl[l-1].sums;
      assign v_in = g_lvl[l-1].v_out;
    end
    mixer_add_stage #(.PAIRS(PAIRS), .W(W)) u_stage (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (v_in),
      .operands  (ops),
      .out_valid (v_out),
      .sums      (sums)
    );
  end

  assign tree_sum   = g_lvl[LEVELS-1].sums;
  assign tree_valid = g_lvl[LEVELS-1].v_out;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      mix_down  <= '0;
    end else begin
      out_valid <= tree_valid;
      if (tree_valid) mix_down <= OUT_W'(tree_sum) << (OUT_W - SUM_W);
    end
  end

  assign cur_sum = mix_down[OUT_W-1 -: SUM_W];

  // Clear-then-compare on a coincident clear collapses to loading the current sum.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      peak_level <= '0;
    end else if (out_valid) begin
      if (peak_clr || (cur_sum > peak_level)) peak_level <= cur_sum;
    end else if (peak_clr) begin
      peak_level <= '0;
    end
  end

endmodule

// File: tb/tb_audio_mixer_n.sv
// Self-checking bench for audio_mixer_n: frame-queue reference model, vector table, corner sequences.
module tb_audio_mixer_n;

  localparam int SHIFT = 21;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] audio_in = '0;
  logic [3:0]  mute = '0;
  logic        gain_we = 1'b0;
  logic [1:0]  gain_sel = '0;
  logic [3:0]  gain_data = '0;
  logic        out_valid;
  logic [31:0] mix_down;
  logic [10:0] peak_level;
  logic        peak_clr = 1'b0;

  audio_mixer_n #(.CHANNELS(4), .IN_W(8), .GAIN_W(4), .OUT_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .audio_in   (audio_in),
    .mute       (mute),
    .gain_we    (gain_we),
    .gain_sel   (gain_sel),
    .gain_data  (gain_data),
    .out_valid  (out_valid),
    .mix_down   (mix_down),
    .peak_level (peak_level),
    .peak_clr   (peak_clr)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned due; int unsigned sum; } exp_t;
  typedef struct { logic [31:0] frame; logic [3:0] mute; logic [3:0] gain; int unsigned exp_sum; } vec_t;

  exp_t        q[$];
  int unsigned m_gain[4];
  bit          m_ov;
  logic [63:0] m_mix;
  int unsigned m_sum, m_peak;
  int unsigned cyc;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned frame_sum(input logic [31:0] f, input logic [3:0] mu);
    int unsigned s = 0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] smp;
      smp = f[c*8 +: 8];
      if (!mu[c]) s += (int'(smp) * m_gain[c]) / 8;
    end
    return s;
  endfunction

  // One clock: model captures inputs at the edge, then DUT outputs are compared 1 ns later.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (in_valid) q.push_back('{due: cyc + LAT - 1, sum: frame_sum(audio_in, mute)});
    if (gain_we) m_gain[gain_sel] = gain_data;
    if (m_ov && peak_clr)               m_peak = m_sum;
    else if (m_ov && m_sum > m_peak)    m_peak = m_sum;
    else if (!m_ov && peak_clr)         m_peak = 0;
    m_ov = (q.size() > 0) && (q[0].due == cyc);
    if (m_ov) begin
      m_sum = q.pop_front().sum;
      m_mix = 64'(m_sum) << SHIFT;
    end
    #1;
    chk("model_out_valid", 64'(out_valid), 64'(m_ov));
    chk("model_mix_down", 64'(mix_down), m_mix);
    chk("model_peak", 64'(peak_level), 64'(m_peak));
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    in_valid = 1'b0; gain_we = 1'b0; peak_clr = 1'b0;
    q.delete();
    for (int c = 0; c < 4; c++) m_gain[c] = 8;
    m_ov = 0; m_mix = '0; m_sum = 0; m_peak = 0;
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mix_down", 64'(mix_down), 64'd0);
    chk("rst_peak", 64'(peak_level), 64'd0);
    resetn = 1'b1;
  endtask

  task automatic set_gain(input int ch, input logic [3:0] g);
    gain_we = 1'b1; gain_sel = 2'(ch); gain_data = g;
    step();
    gain_we = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
  endtask

  task automatic send_expect(input string name, input logic [31:0] f, input logic [3:0] mu, input int unsigned exp);
    int lat;
    audio_in = f; mute = mu; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk({name, "_latency"}, 64'(lat), 64'(LAT));
    chk({name, "_mix"}, 64'(mix_down), 64'(exp) << SHIFT);
    step();
    chk({name, "_peak"}, 64'(peak_level), 64'(exp));
  endtask

  initial begin
    logic [31:0] got[4];
    int lat;

    vecs[0] = '{frame: {8'd40, 8'd30, 8'd20, 8'd10},     mute: 4'b0000, gain: 4'd8,  exp_sum: 100};
    vecs[1] = '{frame: {8'd255, 8'd255, 8'd255, 8'd255}, mute: 4'b0000, gain: 4'd15, exp_sum: 1912};
    vecs[2] = '{frame: {8'd40, 8'd30, 8'd20, 8'd10},     mute: 4'b0101, gain: 4'd8,  exp_sum: 60};
    vecs[3] = '{frame: 32'd0,                            mute: 4'b0000, gain: 4'd8,  exp_sum: 0};
    vecs[4] = '{frame: {8'd0, 8'd255, 8'd0, 8'd255},     mute: 4'b0000, gain: 4'd8,  exp_sum: 510};
    vecs[5] = '{frame: {8'd3, 8'd2, 8'd1, 8'd100},       mute: 4'b0000, gain: 4'd1,  exp_sum: 12};
    vecs[6] = '{frame: {8'd255, 8'd255, 8'd255, 8'd255}, mute: 4'b1111, gain: 4'd15, exp_sum: 0};

    cyc = 0;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_mix", 64'(mix_down), 64'd0);
      chk("idle_peak", 64'(peak_level), 64'd0);
    end

    for (int i = 0; i < 7; i++) begin
      peak_clr = 1'b1;
      step();
      peak_clr = 1'b0;
      for (int c = 0; c < 4; c++) set_gain(c, vecs[i].gain);
      send_expect($sformatf("vec%0d", i), vecs[i].frame, vecs[i].mute, vecs[i].exp_sum);
    end

    // Back-to-back frames with a ch0 gain write coincident with F1.
    apply_reset();
    mute = 4'b0000; in_valid = 1'b1;
    audio_in = {8'd40, 8'd30, 8'd20, 8'd10}; step();
    audio_in = {8'd40, 8'd30, 8'd20, 8'd11};
    gain_we = 1'b1; gain_sel = 2'd0; gain_data = 4'd0; step();
    gain_we = 1'b0;
    audio_in = {8'd40, 8'd30, 8'd20, 8'd12}; step();
    audio_in = {8'd40, 8'd30, 8'd21, 8'd13}; step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("b2b_first_valid", 64'(out_valid), 64'd1);
    got[0] = mix_down;
    for (int k = 1; k < 4; k++) begin
      step();
      chk("b2b_consecutive_valid", 64'(out_valid), 64'd1);
      got[k] = mix_down;
    end
    chk("b2b_f0", 64'(got[0]), 64'(100) << SHIFT);
    chk("b2b_f1", 64'(got[1]), 64'(101) << SHIFT);
    chk("b2b_f2", 64'(got[2]), 64'(90) << SHIFT);
    chk("b2b_f3", 64'(got[3]), 64'(91) << SHIFT);
    repeat (3) step();

    // Reset mid-flight: frame dropped, gains back to unity.
    set_gain(0, 4'd0);
    audio_in = {8'd40, 8'd30, 8'd20, 8'd10}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_valid", 64'(out_valid), 64'd0);
    end
    chk("midrst_peak", 64'(peak_level), 64'd0);
    send_expect("midrst_unity", {8'd40, 8'd30, 8'd20, 8'd10}, 4'b0000, 100);

    // peak_clr coincident with out_valid after a larger peak.
    for (int c = 0; c < 4; c++) set_gain(c, 4'd15);
    send_expect("peak_big", {8'd255, 8'd255, 8'd255, 8'd255}, 4'b0000, 1912);
    for (int c = 0; c < 4; c++) set_gain(c, 4'd8);
    audio_in = 32'd50; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("peakclr_valid", 64'(out_valid), 64'd1);
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    chk("peakclr_coincident", 64'(peak_level), 64'd50);

    // Randomized traffic against the frame-queue model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      audio_in  = $urandom;
      mute      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      gain_we   = ($urandom_range(0, 4) == 0);
      gain_sel  = 2'($urandom);
      gain_data = 4'($urandom);
      peak_clr  = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid = 1'b0; gain_we = 1'b0; peak_clr = 1'b0;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
